grf_sb: RTL
===========

GRF_SB -- requirements
Module: grf_sb

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data width in bits.
REQ-002 SHALL have parameter NREG, default 32, meaning register count (power of 2, 2..64); localparam AW = log2(NREG).
REQ-003 SHALL have parameter NRD, default 2, meaning number of read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning 1 hardwires register 0 to zero.
REQ-005 SHALL have port clk, input, 1, meaning sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-007 SHALL have port rd_addr, input, NRD*AW, meaning read addresses, port k at bits [k*AW +: AW].
REQ-008 SHALL have port rd_data, output, NRD*DW, meaning read data, port k at bits [k*DW +: DW].
REQ-009 SHALL have port rd_pend, output, NRD, meaning addressed register still has an outstanding write.
REQ-010 SHALL have port wr_en, input, 1, meaning writeback strobe.
REQ-011 SHALL have port wr_addr, input, AW, meaning writeback register.
REQ-012 SHALL have port wr_data, input, DW, meaning writeback value.
REQ-013 SHALL have port alloc_en, input, 1, meaning an issued instruction will later write alloc_addr.
REQ-014 SHALL have port alloc_addr, input, AW, meaning register being allocated.
REQ-015 SHALL have port alloc_ovf, output, 1, meaning registered one-cycle pulse: allocation refused.

Function
REQ-016 SHALL keep NREG x DW data registers; wr_en=1 updates reg[wr_addr] at the rising edge, except address 0 when ZERO_REG=1.
REQ-017 SHALL drive rd_data combinationally (0-cycle read); rd_data for address 0 SHALL be 0 when ZERO_REG=1.
REQ-018 SHALL bypass: when wr_en=1 and wr_addr==rd_addr[k] (and not the zero register), rd_data[k] SHALL equal wr_data in the same cycle.
REQ-019 SHALL keep a 2-bit pending counter per register, range 0..3.
REQ-020 Counter update per edge: alloc only -> +1; write only -> -1 (held at 0 if already 0); alloc and write to same address -> unchanged; alloc and write to different addresses -> each applied independently.
REQ-021 alloc_en to a counter at 3 (with no same-cycle write to it) SHALL leave it at 3 and assert alloc_ovf for exactly the next cycle.
REQ-022 alloc_en to address 0 with ZERO_REG=1 SHALL be ignored: no count, no alloc_ovf.
REQ-023 rd_pend[k] SHALL be 1 iff count[rd_addr[k]] >= 2, or count == 1 with no same-cycle wr_en to that address; it SHALL always be 0 for the zero register.
REQ-024 Same-cycle alloc_en SHALL NOT affect rd_pend in that cycle.
REQ-025 A write to a register whose count is 0 SHALL update data normally (an unscoreboarded writer).

Reset
REQ-026 While rst=1: all data registers, all counters, and alloc_ovf SHALL be 0 immediately, regardless of clk.
REQ-027 rd_data SHALL read 0 and rd_pend SHALL read 0 during and right after reset, except rd_data under REQ-018 bypass while wr_en=1.
REQ-028 A reset asserted mid-operation SHALL discard all outstanding allocations; the first edge after deassertion SHALL behave as from cold state.

Structure
REQ-029 The counter width (2), the counter maximum (3) and the reset data value SHALL sit in the shared CPU package next to the existing forwarding-select constants.
REQ-030 Per-register counter logic SHALL be one sub-module, grf_sb_cnt (inputs inc, dec; outputs cnt, ovf), instantiated NREG times in a generate loop.

Verification
REQ-031 Reset then read all addresses -> rd_data=0, rd_pend=0 on every port.
REQ-032 wr_en=1, wr_addr=5, wr_data=32'hDEADBEEF, rd_addr0=5 -> rd_data0=DEADBEEF in the same cycle, and still DEADBEEF after the edge with wr_en=0.
REQ-033 With ZERO_REG=1: write 32'h1234 to reg 0, then alloc reg 0 -> rd_data=0, rd_pend=0, alloc_ovf=0.
REQ-034 Alloc reg 7 four times -> count 1,2,3,3; alloc_ovf pulses exactly once after the 4th; three writes to reg 7 -> rd_pend stays 1 through the 2nd write cycle and is 0 during the 3rd write cycle.
REQ-035 Alloc reg 9 and write reg 9 in the same cycle with count=1 -> count stays 1 and rd_pend=1 next cycle.
REQ-036 Counts 2 on reg 3 and data 32'hA5A5A5A5; assert rst asynchronously between edges -> rd_data and rd_pend go to 0 before the next edge.

Source files
------------

// File: rtl/grf_sb_pkg.sv
// Shared CPU package: forwarding selects and register-scoreboard constants.
package grf_sb_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    localparam int               CNT_W    = 2;
    localparam logic [CNT_W-1:0] CNT_MAX  = 2'd3;
    localparam logic [63:0]      RST_DATA = 64'd0;

endpackage

// File: rtl/grf_sb_cnt.sv
// Saturating outstanding-write counter for one register.
module grf_sb_cnt
    import grf_sb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic inc_only;
    logic dec_only;

    assign inc_only = inc && !dec;
    assign dec_only = dec && !inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            ovf <= inc_only && (cnt == CNT_MAX);
            if (inc_only && (cnt != CNT_MAX))
                cnt <= cnt + CNT_W'(1);
            else if (dec_only && (cnt != '0))
                cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/grf_sb.sv
// General register file with per-register pending-write scoreboard,
// write-to-read bypass and optional hardwired zero register.
module grf_sb
    import grf_sb_pkg::*;
#(
    parameter  int DW       = 32,
    parameter  int NREG     = 32,
    parameter  int NRD      = 2,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    output logic [NRD-1:0]    rd_pend,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    output logic              alloc_ovf
);

    logic [DW-1:0]    regs [NREG];
    logic [CNT_W-1:0] cnt  [NREG];
    logic [NREG-1:0]  inc;
    logic [NREG-1:0]  dec;
    logic [NREG-1:0]  ovf;
    logic             wr_ok;

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign wr_ok = wr_en && !is_zero(wr_addr);

    for (genvar g = 0; g < NREG; g++) begin : g_cnt
        assign inc[g] = alloc_en && (alloc_addr == AW'(g))
                        && !is_zero(AW'(g));
        assign dec[g] = wr_ok && (wr_addr == AW'(g));

        grf_sb_cnt u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (inc[g]),
            .dec (dec[g]),
            .cnt (cnt[g]),
            .ovf (ovf[g])
        );
    end

    // Only one counter can see inc per cycle, so the OR is a single pulse.
    assign alloc_ovf = |ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= DW'(RST_DATA);
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_pend = '0;
        for (int k = 0; k < NRD; k++) begin
            logic [AW-1:0] ra;
            logic          byp;
            ra  = rd_addr[k*AW +: AW];
            byp = wr_ok && (wr_addr == ra);
            if (!is_zero(ra)) begin
                rd_data[k*DW +: DW] = byp ? wr_data : regs[ra];
                // A write landing this cycle retires the last outstanding one.
                rd_pend[k] = (cnt[ra] >= CNT_W'(2))
                             || ((cnt[ra] == CNT_W'(1)) && !byp);
            end
        end
    end

endmodule
